// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between an instruction-fetch and a data requester.
// A single access is in flight at a time. Each access runs IDLE -> BUSY -> DONE, and
// DONE returns a one-cycle ack or err to the requester that owns the access.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_width,
    input  logic        d_signed,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    output logic [1:0]  ram_width,
    input  logic [1:0]  ram_state,
    input  logic [31:0] ram_load
);

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] W_BYTE   = 2'b00;
    localparam logic [1:0] W_HALF   = 2'b01;
    localparam logic [1:0] W_WORD   = 2'b10;
    localparam logic [1:0] RS_DATA  = 2'b10;
    localparam logic [1:0] RS_ERROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Request fields captured at grant time and held for the whole access.
    typedef struct packed {
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wen;
        logic [1:0]    width;
        logic          sgn;
    } req_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    req_t             cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             gnt_req;
    logic             gnt_is_d;
    logic [DW-1:0]    rd_val;

    logic             i_ack_d, i_err_d, d_ack_d, d_err_d;
    logic [DW-1:0]    i_rdata_d, d_rdata_d;
    logic             ram_ren_d, ram_wen_d;
    logic [DW-1:0]    ram_addr_d, ram_store_d;
    logic [1:0]       ram_width_d;

    // Width 11, odd half addresses and non-word-aligned word addresses never reach the RAM.
    function automatic logic is_illegal(input logic [1:0] w, input logic [1:0] a);
        case (w)
            W_BYTE:  is_illegal = 1'b0;
            W_HALF:  is_illegal = a[0];
            W_WORD:  is_illegal = (a != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

    // Loads use the low byte or low half of the RAM word, never a shifted lane.
    function automatic logic [DW-1:0] extend(input logic [DW-1:0] v, input logic [1:0] w,
                                             input logic s);
        case (w)
            W_BYTE:  extend = {{24{s & v[7]}}, v[7:0]};
            W_HALF:  extend = {{16{s & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    // Next-state, arbitration and registered-output values.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        i_rdata_d   = '0;
        d_rdata_d   = '0;
        ram_ren_d   = 1'b0;
        ram_wen_d   = 1'b0;
        ram_addr_d  = '0;
        ram_store_d = '0;
        ram_width_d = '0;

        // D normally wins; I wins whenever D was the previous owner and I is waiting.
        gnt_is_d = d_req & ~(owner_q & i_req);
        if (gnt_is_d) begin
            gnt_req.addr  = d_addr;
            gnt_req.wdata = d_wdata;
            gnt_req.wen   = d_wen;
            gnt_req.width = d_width;
            gnt_req.sgn   = d_signed;
        end else begin
            gnt_req.addr  = i_addr;
            gnt_req.wdata = '0;
            gnt_req.wen   = 1'b0;
            gnt_req.width = W_WORD;
            gnt_req.sgn   = 1'b0;
        end

        rd_val = cur_q.wen ? '0 : extend(ram_load, cur_q.width, cur_q.sgn);

        case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    owner_d = gnt_is_d;
                    cur_d   = gnt_req;
                    cnt_d   = '0;
                    if (is_illegal(gnt_req.width, gnt_req.addr[1:0])) begin
                        state_d = DONE;
                        i_err_d = ~gnt_is_d;
                        d_err_d = gnt_is_d;
                    end else begin
                        state_d     = BUSY;
                        ram_ren_d   = ~gnt_req.wen;
                        ram_wen_d   = gnt_req.wen;
                        ram_addr_d  = gnt_req.addr;
                        ram_store_d = gnt_req.wdata;
                        ram_width_d = gnt_req.width;
                    end
                end
            end
            BUSY: begin
                if (ram_state == RS_DATA) begin
                    state_d = DONE;
                    if (owner_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rd_val;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rd_val;
                    end
                end else if ((ram_state == RS_ERROR) || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d = DONE;
                    i_err_d = ~owner_q;
                    d_err_d = owner_q;
                end else begin
                    ram_ren_d   = ~cur_q.wen;
                    ram_wen_d   = cur_q.wen;
                    ram_addr_d  = cur_q.addr;
                    ram_store_d = cur_q.wdata;
                    ram_width_d = cur_q.width;
                    if (cnt_q != CNT_W'(TIMEOUT)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            cur_q     <= '0;
            cnt_q     <= '0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            ram_width <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            i_ack     <= i_ack_d;
            i_err     <= i_err_d;
            d_ack     <= d_ack_d;
            d_err     <= d_err_d;
            i_rdata   <= i_rdata_d;
            d_rdata   <= d_rdata_d;
            ram_ren   <= ram_ren_d;
            ram_wen   <= ram_wen_d;
            ram_addr  <= ram_addr_d;
            ram_store <= ram_store_d;
            ram_width <= ram_width_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural RAM and a response scoreboard.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_req, i_ack, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wen, d_signed, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_width;
    logic        ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_store;
    logic [1:0]  ram_width;
    logic [1:0]  ram_state = 2'b00;
    logic [31:0] ram_load  = 32'hDEADDEAD;

    typedef struct {
        bit          is_d;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic [1:0]  width;
        logic        sgn;
        logic [31:0] load;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // RAM model controls: mode 0 = data, 1 = error, 2 = hang in ADDR.
    int          lat       = 1;
    int          mode      = 0;
    bit          ram_fixed = 1'b1;
    logic [31:0] ram_data  = 32'h0;
    int          acc_cnt   = 0;
    int          en_cycles = 0;
    logic [31:0] obs_addr, obs_store;
    logic [2:0]  obs_ctl;

    vec_t vecs[10] = '{
        '{32'h080, 32'h0,        1'b0, 2'b00, 1'b1, 32'h000000F0, 1'b0, 32'hFFFFFFF0},
        '{32'h081, 32'h0,        1'b0, 2'b00, 1'b0, 32'h000000F0, 1'b0, 32'h000000F0},
        '{32'h082, 32'h0,        1'b0, 2'b01, 1'b1, 32'h123480F0, 1'b0, 32'hFFFF80F0},
        '{32'h082, 32'h0,        1'b0, 2'b01, 1'b0, 32'h123480F0, 1'b0, 32'h000080F0},
        '{32'h084, 32'h0,        1'b0, 2'b10, 1'b1, 32'h923480F0, 1'b0, 32'h923480F0},
        '{32'h040, 32'hCAFEBABE, 1'b1, 2'b10, 1'b0, 32'h923480F0, 1'b0, 32'h00000000},
        '{32'h102, 32'h0,        1'b0, 2'b10, 1'b0, 32'h923480F0, 1'b1, 32'h00000000},
        '{32'h101, 32'h0,        1'b0, 2'b01, 1'b0, 32'h923480F0, 1'b1, 32'h00000000},
        '{32'h100, 32'h0,        1'b0, 2'b11, 1'b0, 32'h923480F0, 1'b1, 32'h00000000},
        '{32'h103, 32'h000000AB, 1'b1, 2'b00, 1'b0, 32'h923480F0, 1'b0, 32'h00000000}
    };

    mem_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .nrst(nrst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_signed(d_signed),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_width(ram_width), .ram_state(ram_state), .ram_load(ram_load)
    );

    always #5 clk = ~clk;

    // RAM: ADDR for lat enabled cycles, then DATA (or ERROR); load is garbage outside DATA.
    always @(negedge clk) begin
        if (ram_ren || ram_wen) begin
            if (acc_cnt == 0) begin
                obs_addr  = ram_addr;
                obs_store = ram_store;
                obs_ctl   = {ram_wen, ram_width};
            end
            en_cycles++;
            if (mode == 2 || acc_cnt < lat) begin
                ram_state = 2'b01;
                ram_load  = 32'hDEADDEAD;
            end else if (mode == 1) begin
                ram_state = 2'b11;
                ram_load  = 32'hDEADDEAD;
            end else begin
                ram_state = 2'b10;
                ram_load  = ram_fixed ? ram_data : {ram_addr[15:0], 16'hBEEF};
            end
            acc_cnt++;
        end else begin
            ram_state = 2'b00;
            ram_load  = 32'hDEADDEAD;
            acc_cnt   = 0;
        end
    end

    // Monitor: every response is matched against the oldest expected one.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        got_d, got_err;
        logic [31:0] got_rd;
        if (i_ack || i_err || d_ack || d_err) begin
            checks++;
            got_d   = d_ack | d_err;
            got_err = i_err | d_err;
            got_rd  = got_d ? d_rdata : i_rdata;
            if ($countones({i_ack, i_err, d_ack, d_err}) != 1) begin
                errors++;
                $display("FAIL onehot acks=%b required exactly one", {i_ack, i_err, d_ack, d_err});
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp is_d=%0b err=%0b rdata=%h required none",
                         got_d, got_err, got_rd);
            end else begin
                e = exp_q.pop_front();
                if (got_d !== e.is_d || got_err !== e.err || got_rd !== e.rdata) begin
                    errors++;
                    $display("FAIL resp got is_d=%0b err=%0b rdata=%h required is_d=%0b err=%0b rdata=%h",
                             got_d, got_err, got_rd, e.is_d, e.err, e.rdata);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic d_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [1:0] w, input logic s);
        int n;
        d_addr = a; d_wdata = wd; d_wen = we; d_width = w; d_signed = s;
        d_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(d_ack || d_err) && n < 100);
        if (!(d_ack || d_err)) check("d_wait_timeout", 32'(n), 32'(0));
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic i_txn(input logic [31:0] a, input bit drop_early);
        int n;
        i_addr = a;
        i_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop_early) i_req = 1'b0;
        end while (!(i_ack || i_err) && n < 100);
        if (!(i_ack || i_err)) check("i_wait_timeout", 32'(n), 32'(0));
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_width = '0; d_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl", 32'({i_ack, i_err, d_ack, d_err, ram_ren, ram_wen, ram_width}), 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_store", ram_store, 32'h0);
        nrst = 1'b1;
        @(negedge clk);

        // Instruction fetch, RAM answers after three ADDR cycles.
        lat = 3; mode = 0; ram_fixed = 1'b1; ram_data = 32'h12345678; en_cycles = 0;
        exp_q.push_back('{is_d: 1'b0, err: 1'b0, rdata: 32'h12345678});
        i_txn(32'h100, 1'b0);
        check("ifetch_addr", obs_addr, 32'h100);
        check("ifetch_ctl", 32'(obs_ctl), 32'(3'b010));
        check("ifetch_en_cycles", 32'(en_cycles), 32'd4);
        check("ifetch_en_released", 32'({ram_ren, ram_wen}), 32'h0);

        // Data vectors: extension, writes, illegal widths and alignment.
        foreach (vecs[k]) begin
            lat = 1; mode = 0; ram_fixed = 1'b1; ram_data = vecs[k].load; en_cycles = 0;
            obs_addr = 32'hFFFFFFFF; obs_store = 32'hFFFFFFFF; obs_ctl = 3'b111;
            exp_q.push_back('{is_d: 1'b1, err: vecs[k].err, rdata: vecs[k].rdata});
            d_txn(vecs[k].addr, vecs[k].wdata, vecs[k].wen, vecs[k].width, vecs[k].sgn);
            if (vecs[k].err) begin
                check($sformatf("v%0d_no_ram", k), 32'(en_cycles), 32'h0);
            end else begin
                check($sformatf("v%0d_addr", k), obs_addr, vecs[k].addr);
                check($sformatf("v%0d_store", k), obs_store, vecs[k].wdata);
                check($sformatf("v%0d_ctl", k), 32'(obs_ctl), 32'({vecs[k].wen, vecs[k].width}));
            end
            check($sformatf("v%0d_en_released", k), 32'({ram_ren, ram_wen}), 32'h0);
        end

        // RAM signals ERROR.
        lat = 2; mode = 1; en_cycles = 0;
        exp_q.push_back('{is_d: 1'b1, err: 1'b1, rdata: 32'h0});
        d_txn(32'h24, 32'h0, 1'b0, 2'b10, 1'b0);
        check("ramerr_en_cycles", 32'(en_cycles), 32'd3);

        // RAM hangs in ADDR: timeout after 16 BUSY cycles.
        mode = 2; en_cycles = 0;
        exp_q.push_back('{is_d: 1'b1, err: 1'b1, rdata: 32'h0});
        d_txn(32'h20, 32'h0, 1'b0, 2'b10, 1'b0);
        check("timeout_en_cycles", 32'(en_cycles), 32'd16);
        check("timeout_en_released", 32'({ram_ren, ram_wen}), 32'h0);

        // Requester drops i_req mid-access; the ack still arrives.
        mode = 0; lat = 2; ram_data = 32'h0BADF00D;
        exp_q.push_back('{is_d: 1'b0, err: 1'b0, rdata: 32'h0BADF00D});
        i_txn(32'h44, 1'b1);

        // Reset during BUSY aborts silently; a new request is served afterwards.
        mode = 2;
        d_addr = 32'h10; d_width = 2'b10; d_wen = 1'b0; d_signed = 1'b0; d_req = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_busy_ren", 32'(ram_ren), 32'h1);
        nrst = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("midrst_outputs", 32'({i_ack, i_err, d_ack, d_err, ram_ren, ram_wen, ram_width}), 32'h0);
        check("midrst_ram_addr", ram_addr, 32'h0);
        nrst = 1'b1; mode = 0; lat = 1; ram_data = 32'hA5A55A5A;
        @(negedge clk);
        exp_q.push_back('{is_d: 1'b0, err: 1'b0, rdata: 32'hA5A55A5A});
        i_txn(32'h30, 1'b0);

        // Contention from reset: D, then I, then D, then I.
        pulse_reset();
        ram_fixed = 1'b0; lat = 1; mode = 0;
        exp_q.push_back('{is_d: 1'b1, err: 1'b0, rdata: 32'h0200BEEF});
        exp_q.push_back('{is_d: 1'b0, err: 1'b0, rdata: 32'h0300BEEF});
        exp_q.push_back('{is_d: 1'b1, err: 1'b0, rdata: 32'h0208BEEF});
        exp_q.push_back('{is_d: 1'b0, err: 1'b0, rdata: 32'h0304BEEF});
        fork
            begin
                d_txn(32'h200, 32'h0, 1'b0, 2'b10, 1'b0);
                d_txn(32'h208, 32'h0, 1'b0, 2'b10, 1'b0);
            end
            begin
                i_txn(32'h300, 1'b0);
                i_txn(32'h304, 1'b0);
            end
        join

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
